// File: rtl/pipe_nbit_elastic.sv
// pipe_nbit_elastic: elastic valid/ready pipeline of DEPTH register stages
// carrying WIDTH-bit symbols. Each stage stalls independently. Empty stages
// are filled even while the output is stalled, so symbols never drop or duplicate.
// Optional feature: define PIPE_NBIT_OCC_EN to add the registered occupancy port occ.
module pipe_nbit_elastic #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPE_NBIT_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("pipe_nbit_elastic: DEPTH must be >= 1");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("pipe_nbit_elastic: WIDTH must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] data_p [DEPTH];
    logic [DEPTH-1:0] vld_p;
    logic [DEPTH-1:0] rdy;

    // Ready ripples back from the output: a stage can load if it is empty or its successor loads
    always_comb begin
        logic r;
        r   = out_ready;
        rdy = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r      = ~vld_p[i] | r;
            rdy[i] = r;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_p[DEPTH-1];
    assign out_data  = data_p[DEPTH-1];

    // Valid bits advance stage by stage; flush empties every stage at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p <= '0;
        end else if (flush) begin
            vld_p <= '0;
        end else begin
            // stage 0: input boundary
            if (rdy[0]) vld_p[0] <= in_valid;
            // stages 1..DEPTH-1: inter-stage boundaries
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Data follows valid but only moves on a real symbol; bubbles and flushes leave it intact
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) data_p[i] <= '0;
        end else if (!flush) begin
            // stage 0: input boundary
            if (rdy[0] && in_valid) data_p[0] <= in_data;
            // stages 1..DEPTH-1: inter-stage boundaries
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i] && vld_p[i-1]) data_p[i] <= data_p[i-1];
            end
        end
    end

`ifdef PIPE_NBIT_OCC_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Occupancy tracks symbols entering minus symbols leaving, cleared by flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ <= '0;
        end else if (flush) begin
            occ <= '0;
        end else begin
            occ <= occ + OCC_W'(in_fire) - OCC_W'(out_fire);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_nbit_elastic.sv
// tb_pipe_nbit_elastic: directed and randomized bench for pipe_nbit_elastic
// (WIDTH=2, DEPTH=3). The reference model is a FIFO of symbols with their age;
// the oldest symbol is visible at the output once it has aged DEPTH-1 edges.
// Define PIPE_NBIT_OCC_EN to also check the occ port.
module tb_pipe_nbit_elastic;
    localparam int WIDTH = 2;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
`ifdef PIPE_NBIT_OCC_EN
    logic [$clog2(DEPTH+1)-1:0] occ;
`endif

    pipe_nbit_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef PIPE_NBIT_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;
    int lat_in, lat_out, idx;
    int qd[$];
    int qa[$];
    int got[$];
    bit m_rdy, m_ov, acc;
    int s2[5]  = '{1, 0, 2, 1, 3};
    int s3[4]  = '{2, 3, 1, 0};
    int s4[3]  = '{3, 1, 2};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already applied: check, advance model, cross one posedge.
    task automatic step();
        bit in_f, out_f;
        #1;
        m_rdy = (qd.size() < DEPTH) || out_ready;
        m_ov  = (qd.size() > 0) && (qa[0] >= DEPTH - 1);
        check("in_ready", 32'(in_ready), 32'(m_rdy));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) check("out_data", 32'(out_data), qd[0]);
`ifdef PIPE_NBIT_OCC_EN
        check("occ", 32'(occ), qd.size());
`endif
        if (out_valid && out_ready) got.push_back(int'(out_data));
        if (in_valid && in_ready && lat_in < 0) lat_in = cyc;
        if (out_valid && lat_out < 0) lat_out = cyc;
        in_f  = in_valid && m_rdy;
        out_f = m_ov && out_ready;
        acc   = in_f;
        if (out_f) begin
            void'(qd.pop_front());
            void'(qa.pop_front());
        end
        if (flush) begin
            qd.delete();
            qa.delete();
        end else begin
            foreach (qa[i]) qa[i]++;
            if (in_f) begin
                qd.push_back(int'(in_data));
                qa.push_back(0);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        // 1. reset
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        lat_in = -1; lat_out = -1;
        #7;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_NBIT_OCC_EN
        check("rst_occ", 32'(occ), 32'd0);
`endif
        #2 reset = 1'b1;
        @(negedge clk);

        // 2. stream
        out_ready = 1'b1; got.delete(); lat_in = -1; lat_out = -1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 2'(s2[k]); step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("t2_latency", lat_out - lat_in, 32'd3);
        check("t2_count", got.size(), 32'd5);
        for (int k = 0; k < 5; k++) check("t2_order", (k < got.size()) ? got[k] : -1, s2[k]);

        // 3. backpressure
        out_ready = 1'b0; got.delete(); idx = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = 2'(s3[idx]); step();
            if (acc) idx++;
        end
        #1;
        check("t3_in_ready", 32'(in_ready), 32'd0);
        check("t3_accepted", idx, 32'd3);
        check("t3_hold", 32'(out_data), 32'd2);
`ifdef PIPE_NBIT_OCC_EN
        check("t3_occ", 32'(occ), 32'd3);
`endif
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (idx < 4) begin in_valid = 1'b1; in_data = 2'(s3[idx]); end
            else in_valid = 1'b0;
            step();
            if (acc) idx++;
        end
        check("t3_count", got.size(), 32'd4);
        for (int k = 0; k < 4; k++) check("t3_order", (k < got.size()) ? got[k] : -1, s3[k]);

        // 4. bubble collapse
        out_ready = 1'b0; got.delete();
        in_valid = 1'b1; in_data = 2'd3; step();
        in_valid = 1'b0; step(); step();
        #1;
        check("t4_out_valid", 32'(out_valid), 32'd1);
        check("t4_out_data", 32'(out_data), 32'd3);
        check("t4_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_NBIT_OCC_EN
        check("t4_occ", 32'(occ), 32'd1);
`endif
        idx = 1;
        for (int k = 0; k < 4; k++) begin
            if (idx < 3) begin in_valid = 1'b1; in_data = 2'(s4[idx]); end
            else in_valid = 1'b0;
            step();
            if (acc) idx++;
        end
        #1;
        check("t4_accepted", idx, 32'd3);
        check("t4_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1; in_valid = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("t4_count", got.size(), 32'd3);
        for (int k = 0; k < 3; k++) check("t4_order", (k < got.size()) ? got[k] : -1, s4[k]);

        // 5. flush
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 2'd1; step();
        in_data = 2'd3; step();
        flush = 1'b1; in_data = 2'd2; step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("t5_out_valid", 32'(out_valid), 32'd0);
`ifdef PIPE_NBIT_OCC_EN
        check("t5_occ", 32'(occ), 32'd0);
`endif
        got.delete(); out_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("t5_none_out", got.size(), 32'd0);

        // 6. async reset mid-operation
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 2'($urandom_range(1, 3)); step();
        end
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_out_data", 32'(out_data), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_NBIT_OCC_EN
        check("t6_occ", 32'(occ), 32'd0);
`endif
        qd.delete(); qa.delete();
        @(negedge clk);
        reset = 1'b1;

        // 7. randomized traffic against the model
        for (int k = 0; k < 500; k++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = 2'($urandom);
            out_ready = (k % 100 < 50) ? (($urandom % 3) != 0) : (($urandom % 3) == 0);
            flush     = ($urandom % 24) == 0;
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end
endmodule
